melody_sequencer: RTL and testbench
===================================

// Module: melody_sequencer
// PURPOSE
//   Plays a stored melody by sequencing the octave/note inputs of the tone LUT note selector.
//   Steps through song ROM entries, each holding {octave, note, duration}. Holds each note for its
//   duration in ticks, then inserts a 1-tick articulation gap.
//   Arbitrates the selector between the sequencer and a manual key source; the manual source wins.
// PARAMETERS
//   clk_mhz     50                        board clock, MHz
//   note_width  4                         note code width; codes 12..15 = silence
//   song_len    16                        ROM entries; addr width AW = $clog2(song_len)
//   tick_cycles clk_mhz*1000*125          clocks per tick (125 ms = 1/16 note @120 bpm)
// PORTS
//   clk         in   1           clock
//   reset       in   1           asynchronous, active-high
//   start       in   1           1-cycle pulse: begin playback from entry 0
//   stop        in   1           1-cycle pulse: abort playback
//   loop_en     in   1           restart at entry 0 on end-of-song
//   key_valid   in   1           manual key held; overrides sequencer output
//   key_octave  in   3           manual octave
//   key_note    in   note_width  manual note
//   octave      out  3           to note selector
//   note        out  note_width  to note selector
//   busy        out  1           sequencer not IDLE
//   done        out  1           1-cycle pulse on natural end-of-song (not on stop)
//   step_idx    out  AW          current ROM address
// BEHAVIOUR
//   Reset: state IDLE, step_idx 0, note NOTE_SILENCE (4'hF), octave 0, busy 0, done 0, tick counters 0.
//   FSM: IDLE -> FETCH -> PLAY -> [GAP] -> FETCH ... -> IDLE.
//   IDLE: on start (stop low) -> FETCH, step_idx <= 0. start while busy is ignored.
//   FETCH (1 cycle): read ROM[step_idx].
//     - dur == 0 or step_idx == song_len (past end) is end-of-song:
//       - loop_en=1 and step_idx != 0 -> step_idx <= 0, stay FETCH.
//       - otherwise -> IDLE, done=1 for one cycle.
//     - Else -> PLAY. Latch entry, clear prescaler and tick count.
//   PLAY: seq note/octave = latched entry. Prescaler counts 0..tick_cycles-1; wrap = one tick.
//     - dur >= 2: after dur-1 ticks -> GAP.
//     - dur == 1: after 1 tick -> FETCH, no gap.
//   GAP: seq note = NOTE_SILENCE for 1 tick. Then step_idx+1 -> FETCH.
//   Note starts are tick-aligned to FETCH; prescaler restarts for every note.
//   stop: any state -> IDLE next cycle, seq note = SILENCE, step_idx kept, no done.
//     stop wins over a simultaneous start.
//   Latency: start sampled at cycle N -> busy=1 at N+1 (FETCH) -> note/octave valid at N+2.
//   Output mux (registered, 1 cycle): key_valid ? key_* : seq_*.
//     Seq timing continues unaffected under override.
//     Key release -> seq value on the next cycle.
//   busy = (state != IDLE), registered together with the state.
//   Width rules:
//     - prescaler width $clog2(tick_cycles).
//     - tick count 4 bit; compare against dur-1 with no underflow (dur==1 handled separately).
//     - step_idx increments at AW+1 bits internally so song_len may be a power of 2.
// STRUCTURE
//   Package melody_pkg:
//     - typedef struct packed {logic [2:0] octave; logic [3:0] note; logic [3:0] dur;} song_entry_t;
//     - localparam NOTE_SILENCE = 4'hF.
//     - typedef enum {IDLE, FETCH, PLAY, GAP} seq_state_t.
//   Sub-module melody_rom:
//     - combinational, addr[AW-1:0] -> song_entry_t.
//     - case table; dur 0 terminates the song.
//   No other sub-modules; prescaler, tick counter and FSM live in this file.
// TESTING (tick_cycles=4; ROM: {4,C,2},{4,E,1},{5,A,3},{x,x,0})
//   1. Reset mid-PLAY -> next cycle: note=4'hF, octave=0, busy=0, done=0, step_idx=0.
//   2. Basic sequence: start at N -> busy at N+1.
//      - note=0 (C), oct 4 at N+2 for 4 clks, then 4'hF for 4 clks (gap).
//      - then E for 4 clks, no gap.
//      - then A (9), oct 5 for 8 clks, then gap 4 clks.
//      - done 1-cycle pulse, busy=0.
//   3. loop_en=1: after the A gap, step_idx returns 0 and C replays; done never asserts.
//      - Clear loop_en -> done pulses at the next end.
//   4. stop during E at step_idx=1 -> next cycle busy=0, note=4'hF, no done.
//      - start+stop in same cycle from IDLE -> stays IDLE.
//   5. key_valid=1, key_note=7, key_octave=2 during playback -> note=7/oct=2 one cycle later.
//      - Release -> sequencer note at its scheduled position; total song cycle count unchanged.
//   6. start pulses while busy -> ignored (step_idx and note timing unchanged).
//      - ROM with entry0.dur=0 and loop_en=1 -> done after one FETCH, no hang.

Source files
------------

// File: rtl/melody_pkg.sv
// Shared types for the melody sequencer: song ROM entry layout, silence code and FSM states.
package melody_pkg;

  typedef struct packed {
    logic [2:0] octave;
    logic [3:0] note;
    logic [3:0] dur;
  } song_entry_t;

  localparam logic [3:0] NOTE_SILENCE = 4'hF;

  typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} seq_state_t;

endpackage

// File: rtl/melody_rom.sv
// Song table lookup; an entry with dur 0 terminates the song.
module melody_rom
  import melody_pkg::*;
#(
  parameter int aw       = 4,
  parameter int song_sel = 0
) (
  input  logic [aw-1:0] addr,
  output song_entry_t   entry
);

  always_comb begin
    entry = '{octave: 3'd0, note: NOTE_SILENCE, dur: 4'd0};
    if (song_sel == 0) begin
      case (int'(addr))
        0:       entry = '{octave: 3'd4, note: 4'd0, dur: 4'd2};
        1:       entry = '{octave: 3'd4, note: 4'd4, dur: 4'd1};
        2:       entry = '{octave: 3'd5, note: 4'd9, dur: 4'd3};
        default: entry = '{octave: 3'd0, note: NOTE_SILENCE, dur: 4'd0};
      endcase
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// Steps through the song ROM driving octave/note of the tone selector, with a manual key
// override on a registered output mux.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int  clk_mhz     = 50,
  parameter int  note_width  = 4,
  parameter int  song_len    = 16,
  parameter int  tick_cycles = clk_mhz * 1000 * 125,
  parameter int  song_sel    = 0,
  localparam int AW          = (song_len > 1) ? $clog2(song_len) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic                  key_valid,
  input  logic [2:0]            key_octave,
  input  logic [note_width-1:0] key_note,
  output logic [2:0]            octave,
  output logic [note_width-1:0] note,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         step_idx
);

  localparam int                PW        = (tick_cycles > 1) ? $clog2(tick_cycles) : 1;
  localparam logic [PW-1:0]     PRESC_MAX = PW'(tick_cycles - 1);
  localparam logic [AW:0]       STEP_END  = (AW + 1)'(song_len);
  localparam logic [note_width-1:0] SILENCE = note_width'(NOTE_SILENCE);

  seq_state_t              state_q, state_d;
  logic [AW:0]             step_q, step_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [3:0]              tick_q, tick_d;
  logic [3:0]              dur_q, dur_d;
  logic [note_width-1:0]   seq_note_q, seq_note_d;
  logic [2:0]              seq_oct_q, seq_oct_d;
  logic [note_width-1:0]   note_q, note_d;
  logic [2:0]              octave_q, octave_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    tick_wrap;
  logic [3:0]              tick_inc;
  song_entry_t             rom_entry;

  melody_rom #(
    .aw       (AW),
    .song_sel (song_sel)
  ) u_rom (
    .addr  (step_q[AW-1:0]),
    .entry (rom_entry)
  );

  assign tick_wrap = (presc_q == PRESC_MAX);
  assign tick_inc  = tick_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    presc_d    = presc_q;
    tick_d     = tick_q;
    dur_d      = dur_q;
    seq_note_d = seq_note_q;
    seq_oct_d  = seq_oct_q;
    done_d     = 1'b0;

    if (stop) begin
      state_d    = IDLE;
      seq_note_d = SILENCE;
      seq_oct_d  = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = FETCH;
            step_d  = '0;
          end
        end
        FETCH: begin
          if (rom_entry.dur == 4'd0 || step_q == STEP_END) begin
            // Looping from entry 0 would spin forever on an empty song, so end it instead.
            if (loop_en && step_q != '0) begin
              step_d = '0;
            end else begin
              state_d    = IDLE;
              done_d     = 1'b1;
              seq_note_d = SILENCE;
              seq_oct_d  = 3'd0;
            end
          end else begin
            state_d    = PLAY;
            dur_d      = rom_entry.dur;
            seq_note_d = note_width'(rom_entry.note);
            seq_oct_d  = rom_entry.octave;
            presc_d    = '0;
            tick_d     = 4'd0;
          end
        end
        PLAY: begin
          presc_d = tick_wrap ? '0 : presc_q + 1'b1;
          if (tick_wrap) begin
            tick_d = tick_inc;
            if (dur_q == 4'd1) begin
              state_d = FETCH;
              step_d  = step_q + 1'b1;
            end else if (tick_inc == dur_q - 4'd1) begin
              state_d    = GAP;
              seq_note_d = SILENCE;
              seq_oct_d  = 3'd0;
            end
          end
        end
        GAP: begin
          presc_d = tick_wrap ? '0 : presc_q + 1'b1;
          if (tick_wrap) begin
            state_d = FETCH;
            step_d  = step_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d   = (state_d != IDLE);
    // The mux looks at the next sequencer value so a new note shows up with the state change.
    note_d   = key_valid ? key_note : seq_note_d;
    octave_d = key_valid ? key_octave : seq_oct_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      step_q     <= '0;
      presc_q    <= '0;
      tick_q     <= 4'd0;
      dur_q      <= 4'd0;
      seq_note_q <= SILENCE;
      seq_oct_q  <= 3'd0;
      note_q     <= SILENCE;
      octave_q   <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      dur_q      <= dur_d;
      seq_note_q <= seq_note_d;
      seq_oct_q  <= seq_oct_d;
      note_q     <= note_d;
      octave_q   <= octave_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign note     = note_q;
  assign octave   = octave_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = step_q[AW-1:0];

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer with a 4-clock tick and the short test song.
module tb_melody_sequencer;

  localparam int TICK = 4;

  logic       clk = 1'b0;
  logic       reset, start, stop, loop_en, key_valid;
  logic [2:0] key_octave;
  logic [3:0] key_note;
  logic [2:0] octave, e_octave;
  logic [3:0] note, e_note;
  logic       busy, done, e_busy, e_done;
  logic [3:0] step_idx, e_step_idx;

  always #5 clk = ~clk;

  melody_sequencer #(
    .clk_mhz(50), .note_width(4), .song_len(16), .tick_cycles(TICK), .song_sel(0)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .key_valid(key_valid), .key_octave(key_octave), .key_note(key_note),
    .octave(octave), .note(note), .busy(busy), .done(done), .step_idx(step_idx)
  );

  // Second instance holds an empty song (entry 0 has dur 0).
  melody_sequencer #(
    .clk_mhz(50), .note_width(4), .song_len(16), .tick_cycles(TICK), .song_sel(1)
  ) dut_e (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .key_valid(key_valid), .key_octave(key_octave), .key_note(key_note),
    .octave(e_octave), .note(e_note), .busy(e_busy), .done(e_done), .step_idx(e_step_idx)
  );

  typedef struct packed {
    logic [3:0] note;
    logic [2:0] oct;
    logic       busy;
    logic       done;
    logic [3:0] step;
  } obs_t;

  typedef struct {
    int         n;
    logic [3:0] note;
    logic [2:0] oct;
    logic [3:0] step;
  } seg_t;

  obs_t exp_q[$];
  seg_t body[9];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic obs_t mk(logic [3:0] n, logic [2:0] o, logic b, logic d, logic [3:0] s);
    obs_t r;
    r.note = n; r.oct = o; r.busy = b; r.done = d; r.step = s;
    return r;
  endfunction

  function automatic obs_t dut_obs();
    return mk(note, octave, busy, done, step_idx);
  endfunction

  function automatic obs_t e_obs();
    return mk(e_note, e_octave, e_busy, e_done, e_step_idx);
  endfunction

  task automatic check_obs(string name, obs_t act, obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got note=%h oct=%0d busy=%b done=%b step=%0d, required note=%h oct=%0d busy=%b done=%b step=%0d",
               name, $time, act.note, act.oct, act.busy, act.done, act.step,
               exp.note, exp.oct, exp.busy, exp.done, exp.step);
    end else begin
      $display("ok   %s t=%0t: note=%h oct=%0d busy=%b done=%b step=%0d",
               name, $time, act.note, act.oct, act.busy, act.done, act.step);
    end
  endtask

  // One clock: the record sampled after the edge reflects the key inputs seen at that edge.
  task automatic cycle(string name);
    logic       kv;
    logic [3:0] kn;
    logic [2:0] ko;
    obs_t       exp;
    kv = key_valid; kn = key_note; ko = key_octave;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s t=%0t: no expected record queued, got note=%h busy=%b", name, $time, note, busy);
    end else begin
      exp = exp_q.pop_front();
      if (kv) begin
        exp.note = kn;
        exp.oct  = ko;
      end
      check_obs(name, dut_obs(), exp);
    end
  endtask

  task automatic run(string name, int n);
    for (int i = 0; i < n; i++) cycle(name);
  endtask

  task automatic drain(string name);
    while (exp_q.size() > 0) cycle(name);
  endtask

  task automatic push_body();
    foreach (body[i])
      for (int k = 0; k < body[i].n; k++)
        exp_q.push_back(mk(body[i].note, body[i].oct, 1'b1, 1'b0, body[i].step));
  endtask

  task automatic push_end();
    exp_q.push_back(mk(4'hF, 3'd0, 1'b0, 1'b1, 4'd3));
    exp_q.push_back(mk(4'hF, 3'd0, 1'b0, 1'b0, 4'd3));
  endtask

  task automatic start_play(string name);
    start = 1'b1;
    cycle(name);
    start = 1'b0;
  endtask

  initial begin
    // Visible per-cycle trace of one pass through the song, starting at the FETCH after start.
    body[0] = '{1, 4'hF, 3'd0, 4'd0};
    body[1] = '{4, 4'd0, 3'd4, 4'd0};
    body[2] = '{4, 4'hF, 3'd0, 4'd0};
    body[3] = '{1, 4'hF, 3'd0, 4'd1};
    body[4] = '{4, 4'd4, 3'd4, 4'd1};
    body[5] = '{1, 4'd4, 3'd4, 4'd2};
    body[6] = '{8, 4'd9, 3'd5, 4'd2};
    body[7] = '{4, 4'hF, 3'd0, 4'd2};
    body[8] = '{1, 4'hF, 3'd0, 4'd3};

    reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    key_valid = 1'b0; key_note = 4'd0; key_octave = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check_obs("reset_state", dut_obs(), mk(4'hF, 3'd0, 1'b0, 1'b0, 4'd0));
    check_obs("reset_state_e", e_obs(), mk(4'hF, 3'd0, 1'b0, 1'b0, 4'd0));
    reset = 1'b0;
    exp_q.push_back(mk(4'hF, 3'd0, 1'b0, 1'b0, 4'd0));
    cycle("idle");

    // Basic playback to natural end.
    push_body();
    push_end();
    start_play("basic");
    drain("basic");

    // Loop twice, then clear loop_en so the second pass ends with done.
    loop_en = 1'b1;
    push_body();
    push_body();
    push_end();
    start_play("loop");
    run("loop", 38);
    loop_en = 1'b0;
    drain("loop");

    // Stop during E at step 1; then start+stop together from IDLE.
    push_body();
    start_play("stop_run");
    run("stop_run", 11);
    exp_q.delete();
    stop = 1'b1;
    repeat (3) exp_q.push_back(mk(4'hF, 3'd0, 1'b0, 1'b0, 4'd1));
    cycle("stop");
    stop = 1'b0;
    drain("stop_idle");
    start = 1'b1; stop = 1'b1;
    repeat (3) exp_q.push_back(mk(4'hF, 3'd0, 1'b0, 1'b0, 4'd1));
    cycle("start_stop");
    start = 1'b0; stop = 1'b0;
    drain("start_stop_idle");

    // Manual key override across the C/gap boundary; song length must be unchanged.
    push_body();
    push_end();
    start_play("key");
    run("key", 2);
    key_valid = 1'b1; key_note = 4'd7; key_octave = 3'd2;
    run("key", 6);
    key_valid = 1'b0;
    drain("key");

    // Start pulses while busy are ignored.
    push_body();
    push_end();
    start_play("busy_start");
    for (int i = 0; i < 26; i++) begin
      start = ((i % 5) == 2);
      cycle("busy_start");
    end
    start = 1'b0;
    drain("busy_start");

    // Asynchronous reset while A is playing.
    push_body();
    start_play("reset_run");
    run("reset_run", 16);
    exp_q.delete();
    reset = 1'b1;
    #2;
    check_obs("reset_mid_play", dut_obs(), mk(4'hF, 3'd0, 1'b0, 1'b0, 4'd0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.push_back(mk(4'hF, 3'd0, 1'b0, 1'b0, 4'd0));
    cycle("after_reset");

    // Empty song with loop_en: one FETCH then done, no hang.
    loop_en = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_obs("empty_fetch", e_obs(), mk(4'hF, 3'd0, 1'b1, 1'b0, 4'd0));
    @(posedge clk);
    #1;
    check_obs("empty_done", e_obs(), mk(4'hF, 3'd0, 1'b0, 1'b1, 4'd0));
    @(posedge clk);
    #1;
    check_obs("empty_idle", e_obs(), mk(4'hF, 3'd0, 1'b0, 1'b0, 4'd0));
    stop = 1'b1;
    loop_en = 1'b0;
    @(posedge clk);
    #1;
    stop = 1'b0;
    check_obs("final_stop", dut_obs(), mk(4'hF, 3'd0, 1'b0, 1'b0, 4'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
